// File: rtl/usbf_evt_sync_pkg.sv
// -----------------------------------------------------------------------------
// usbf_evt_sync_pkg
// Shared definitions for the event synchronizer: per-channel edge-mode
// encodings and the helper that decides whether an accepted level change
// counts as an event for a given mode.
// -----------------------------------------------------------------------------
package usbf_evt_sync_pkg;

    // Per-channel edge mode, two bits per channel on mode_i.
    typedef enum logic [1:0] {
        EVT_MODE_NONE = 2'b00,
        EVT_MODE_RISE = 2'b01,
        EVT_MODE_FALL = 2'b10,
        EVT_MODE_BOTH = 2'b11
    } evt_mode_e;

    localparam int unsigned MODE_W = 2;

    // new_level is the value level_o is about to take; the caller only asks
    // when the level is actually changing, so new_level alone gives direction.
    function automatic logic edge_match(input logic [MODE_W-1:0] mode,
                                        input logic              new_level);
        logic hit;
        hit = 1'b0;
        case (evt_mode_e'(mode))
            EVT_MODE_RISE: hit = new_level;
            EVT_MODE_FALL: hit = ~new_level;
            EVT_MODE_BOTH: hit = 1'b1;
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/usbf_evt_sync_ch.sv
// -----------------------------------------------------------------------------
// usbf_evt_sync_ch
// One event channel: STAGES-deep synchronizer, glitch filter, edge detector
// and sticky pending / overflow flags.
//
// Ports
//   hclk_i      in   1       clock, rising edge
//   rst_i       in   1       synchronous active-high reset
//   async_i     in   1       raw asynchronous input
//   filt_len_i  in   FILT_W  filter length (change accepted after len+1
//                            consecutive mismatching cycles)
//   mode_i      in   2       edge mode (none / rise / fall / both)
//   ack_i       in   1       clears pend_o and ovf_o
//   level_o     out  1       synchronized, filtered level
//   pulse_o     out  1       one-cycle event strobe
//   pend_o      out  1       sticky event pending
//   ovf_o       out  1       sticky overflow (event lost while pending)
// -----------------------------------------------------------------------------
module usbf_evt_sync_ch
    import usbf_evt_sync_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int FILT_W = 4
) (
    input  logic              hclk_i,
    input  logic              rst_i,
    input  logic              async_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              ack_i,
    output logic              level_o,
    output logic              pulse_o,
    output logic              pend_o,
    output logic              ovf_o
);

    logic [STAGES-1:0] sync_q;
    logic [FILT_W-1:0] cnt_q;
    logic              level_q;
    logic              pulse_q;
    logic              pend_q;
    logic              ovf_q;

    logic              sync;
    logic              mismatch;
    logic              accept;
    logic              evt;

    logic [FILT_W-1:0] cnt_d;
    logic              level_d;
    logic              pend_d;
    logic              ovf_d;

    assign sync = sync_q[STAGES-1];

    always_comb begin
        mismatch = (sync != level_q);
        // >= rather than == so a shrinking filt_len_i mid-count cannot leave
        // the counter stranded above the new threshold.
        accept   = mismatch && (cnt_q >= filt_len_i);
        evt      = accept && edge_match(mode_i, sync);

        cnt_d    = cnt_q;
        level_d  = level_q;
        if (!mismatch) begin
            cnt_d = '0;
        end else if (accept) begin
            level_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end

        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (evt) begin
            // A new event always sets pending. An ack on the same edge
            // consumes the earlier event, so overflow is cleared rather than
            // set; without ack, an event on top of a pending one is lost.
            pend_d = 1'b1;
            if (ack_i) begin
                ovf_d = 1'b0;
            end else if (pend_q) begin
                ovf_d = 1'b1;
            end
        end else if (ack_i) begin
            pend_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= evt;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign pend_o  = pend_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/usbf_evt_sync.sv
// -----------------------------------------------------------------------------
// usbf_evt_sync
// CH independent asynchronous event inputs, each synchronized, glitch
// filtered and edge detected with sticky pending/overflow flags. All state
// lives in the per-channel instances.
//
// Ports
//   hclk_i      in   1       clock, rising edge
//   rst_i       in   1       synchronous active-high reset
//   async_i     in   CH      raw asynchronous inputs
//   filt_len_i  in   FILT_W  shared filter length
//   mode_i      in   2*CH    edge mode, channel n at [2n+1:2n]
//   ack_i       in   CH      per-channel clear of pend_o / ovf_o
//   level_o     out  CH      synchronized, filtered levels
//   pulse_o     out  CH      one-cycle event strobes
//   pend_o      out  CH      sticky pending flags
//   ovf_o       out  CH      sticky overflow flags
// -----------------------------------------------------------------------------
module usbf_evt_sync
    import usbf_evt_sync_pkg::*;
#(
    parameter int CH     = 8,
    parameter int STAGES = 2,
    parameter int FILT_W = 4
) (
    input  logic                 hclk_i,
    input  logic                 rst_i,
    input  logic [CH-1:0]        async_i,
    input  logic [FILT_W-1:0]    filt_len_i,
    input  logic [MODE_W*CH-1:0] mode_i,
    input  logic [CH-1:0]        ack_i,
    output logic [CH-1:0]        level_o,
    output logic [CH-1:0]        pulse_o,
    output logic [CH-1:0]        pend_o,
    output logic [CH-1:0]        ovf_o
);

    for (genvar n = 0; n < CH; n++) begin : g_ch
        usbf_evt_sync_ch #(
            .STAGES (STAGES),
            .FILT_W (FILT_W)
        ) u_ch (
            .hclk_i     (hclk_i),
            .rst_i      (rst_i),
            .async_i    (async_i[n]),
            .filt_len_i (filt_len_i),
            .mode_i     (mode_i[MODE_W*n +: MODE_W]),
            .ack_i      (ack_i[n]),
            .level_o    (level_o[n]),
            .pulse_o    (pulse_o[n]),
            .pend_o     (pend_o[n]),
            .ovf_o      (ovf_o[n])
        );
    end

endmodule
